// File: rtl/serial2parallel_pkg.sv
// Shared helpers for the io components: counter width calculation and the
// minimum main-clock to serial-clock oversampling ratio.
package serial2parallel_pkg;

   localparam int CLK_RATIO_MIN = 4;

   // Bits needed for a counter that runs 0..n-1 (never less than one bit).
   function automatic int get_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/serial2parallel_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus a third flop that
// turns the synchronized level into a single-cycle rising-edge pulse.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic q,
   output logic rise
);

   logic [2:0] sr;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the values from before the clock edge, never a partial update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= '0;
      else        sr <= {sr[1:0], din};
   end

   assign q    = sr[1];
   assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/serial2parallel.sv
// Receiver for the s_clk/s_clr/s_dat shift-register link: oversamples the
// lines, reassembles DATA_BITS-wide words and strobes valid per word.
// Optional mid-word watchdog: define S2P_TIMEOUT_EN.
module serial2parallel
   import serial2parallel_pkg::*;
#(
   parameter int P_CLK_FREQ  = 100,
   parameter int S_CLK_FREQ  = 20,
   parameter int DATA_BITS   = 16,
   parameter int CODE_ENDIAN = 1,
   parameter int TIMEOUT_US  = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_clk,
   input  logic                 s_clr,
   input  logic                 s_dat,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 busy,
   output logic                 timeout
);

   localparam int CW = get_width(DATA_BITS);

   if (P_CLK_FREQ < CLK_RATIO_MIN * S_CLK_FREQ) begin : g_ratio_check
      $error("serial2parallel: P_CLK_FREQ must be at least %0d * S_CLK_FREQ", CLK_RATIO_MIN);
   end
   if (DATA_BITS < 2 || DATA_BITS > 64) begin : g_width_check
      $error("serial2parallel: DATA_BITS must be in 2..64");
   end
   if (TIMEOUT_US < 1) begin : g_timeout_check
      $error("serial2parallel: TIMEOUT_US must be at least 1");
   end

   logic sck_rise, clr_s, dat_s;
   logic sck_q_unused, clr_rise_unused, dat_rise_unused;

   sync_edge u_sync_sck (.clk(clk), .rst_n(rst_n), .din(s_clk), .q(sck_q_unused), .rise(sck_rise));
   sync_edge u_sync_clr (.clk(clk), .rst_n(rst_n), .din(s_clr), .q(clr_s), .rise(clr_rise_unused));
   sync_edge u_sync_dat (.clk(clk), .rst_n(rst_n), .din(s_dat), .q(dat_s), .rise(dat_rise_unused));

   logic [CW-1:0]        cnt;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] word_next;
   logic                 last_bit;
   logic                 expire;

   assign word_next = (CODE_ENDIAN != 0) ? {shreg[DATA_BITS-2:0], dat_s}
                                         : {dat_s, shreg[DATA_BITS-1:1]};
   assign last_bit  = (cnt == CW'(DATA_BITS - 1));

`ifdef S2P_TIMEOUT_EN
   localparam int WD_LIMIT = P_CLK_FREQ * TIMEOUT_US;
   localparam int WW       = get_width(WD_LIMIT);

   logic [WW-1:0] wd;

   assign expire = busy && (wd == WW'(WD_LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= expire;
         if (!busy || sck_rise || expire) wd <= '0;
         else                             wd <= wd + 1'b1;
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   // NOTE: the shift register is reset along with the control state so a
   // word started after reset never carries bits from before it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         busy  <= 1'b0;
         shreg <= '0;
         data  <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (clr_s) begin
            cnt  <= '0;
            busy <= 1'b0;
         end else if (sck_rise) begin
            shreg <= word_next;
            if (expire) begin
               // Watchdog fired on this edge: the bit starts a fresh word.
               cnt  <= CW'(1);
               busy <= 1'b1;
            end else if (last_bit) begin
               data  <= word_next;
               valid <= 1'b1;
               cnt   <= '0;
               busy  <= 1'b0;
            end else begin
               cnt  <= cnt + 1'b1;
               busy <= 1'b1;
            end
         end else if (expire) begin
            cnt  <= '0;
            busy <= 1'b0;
         end
      end
   end

endmodule
